// File: rtl/iob_ethmac_mem_arbiter_pkg.sv
// Shared encodings for the two-requester IOb memory arbiter.
package iob_ethmac_mem_arbiter_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } arb_state_e;

    localparam logic REQ_DMA = 1'b0;
    localparam logic REQ_CPU = 1'b1;

endpackage

// File: rtl/iob_rr_arb2.sv
// Combinational 2-way round-robin pick: on a tie the requester not served last wins.
module iob_rr_arb2
    import iob_ethmac_mem_arbiter_pkg::*;
(
    input  logic [1:0] valid_i,
    input  logic       prio_i,
    output logic       idx_o,
    output logic       any_o
);

    always_comb begin
        any_o = |valid_i;
        idx_o = REQ_DMA;
        if (valid_i == 2'b11) begin
            idx_o = ~prio_i;
        end else if (valid_i[1]) begin
            idx_o = REQ_CPU;
        end
    end

endmodule

// File: rtl/iob_ethmac_mem_arbiter.sv
// Shares one IOb memory port between the ethmac DMA (r0) and a CPU data port (r1).
// One transaction in flight; grant is held until the memory returns ready.
module iob_ethmac_mem_arbiter
    import iob_ethmac_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                r0_valid,
    input  logic [ADDR_W-1:0]   r0_addr,
    input  logic [DATA_W-1:0]   r0_wdata,
    input  logic [DATA_W/8-1:0] r0_wstrb,
    output logic [DATA_W-1:0]   r0_rdata,
    output logic                r0_ready,

    input  logic                r1_valid,
    input  logic [ADDR_W-1:0]   r1_addr,
    input  logic [DATA_W-1:0]   r1_wdata,
    input  logic [DATA_W/8-1:0] r1_wstrb,
    output logic [DATA_W-1:0]   r1_rdata,
    output logic                r1_ready,

    output logic                m_valid,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_ready,

    output logic                busy,
    output logic                grant
);

    arb_state_e state_q, state_d;
    logic       grant_q, grant_d;
    logic       prio_q, prio_d;
    logic       arb_idx, arb_any;
    logic       sel_valid;
    logic       in_busy;

    iob_rr_arb2 u_rr_arb2 (
        .valid_i ({r1_valid, r0_valid}),
        .prio_i  (prio_q),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    assign in_busy   = (state_q == StBusy);
    assign sel_valid = (grant_q == REQ_CPU) ? r1_valid : r0_valid;
    assign busy      = in_busy;
    assign grant     = grant_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        prio_d  = prio_q;
        unique case (state_q)
            StIdle: begin
                // Spurious m_ready here is ignored.
                if (arb_any) begin
                    state_d = StBusy;
                    grant_d = arb_idx;
                end
            end
            StBusy: begin
                if (m_ready) begin
                    state_d = StIdle;
                    prio_d  = grant_q;
                end else if (!sel_valid) begin
                    // Owner withdrew its request: abandon without a ready, keep prio.
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            grant_q <= REQ_DMA;
            prio_q  <= REQ_CPU;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            prio_q  <= prio_d;
        end
    end

    always_comb begin
        m_valid  = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        m_wstrb  = '0;
        r0_ready = 1'b0;
        r1_ready = 1'b0;
        r0_rdata = '0;
        r1_rdata = '0;
        if (in_busy) begin
            m_valid = sel_valid;
            if (grant_q == REQ_CPU) begin
                m_addr  = r1_addr;
                m_wdata = r1_wdata;
                m_wstrb = r1_wstrb;
            end else begin
                m_addr  = r0_addr;
                m_wdata = r0_wdata;
                m_wstrb = r0_wstrb;
            end
            if (m_ready) begin
                if (grant_q == REQ_CPU) begin
                    r1_ready = 1'b1;
                    r1_rdata = m_rdata;
                end else begin
                    r0_ready = 1'b1;
                    r0_rdata = m_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_iob_ethmac_mem_arbiter.sv
// Directed bench for iob_ethmac_mem_arbiter with a latency-programmable memory model
// and an in-order scoreboard of expected completions.
module tb_iob_ethmac_mem_arbiter;

    localparam logic [31:0] KEY = 32'hDEADBFEF;  // 0x100 ^ KEY = 0xDEADBEEF

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_valid, r1_valid;
    logic [31:0] r0_addr, r1_addr, r0_wdata, r1_wdata;
    logic [3:0]  r0_wstrb, r1_wstrb;
    logic [31:0] r0_rdata, r1_rdata;
    logic        r0_ready, r1_ready;
    logic        m_valid, m_ready;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic        busy, grant;

    logic        spur = 1'b0;
    int unsigned lat = 0;
    int unsigned cnt = 0;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;

    iob_ethmac_mem_arbiter #(
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .r0_valid (r0_valid),
        .r0_addr  (r0_addr),
        .r0_wdata (r0_wdata),
        .r0_wstrb (r0_wstrb),
        .r0_rdata (r0_rdata),
        .r0_ready (r0_ready),
        .r1_valid (r1_valid),
        .r1_addr  (r1_addr),
        .r1_wdata (r1_wdata),
        .r1_wstrb (r1_wstrb),
        .r1_rdata (r1_rdata),
        .r1_ready (r1_ready),
        .m_valid  (m_valid),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_wstrb  (m_wstrb),
        .m_rdata  (m_rdata),
        .m_ready  (m_ready),
        .busy     (busy),
        .grant    (grant)
    );

    always #5 clk = ~clk;

    // Memory model: ready after `lat` cycles of m_valid, data derived from address.
    assign m_rdata = m_addr ^ KEY;
    assign m_ready = (m_valid && (cnt == lat)) || spur;

    always @(posedge clk) begin
        if (m_valid && !m_ready) cnt <= cnt + 1;
        else cnt <= 0;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic req, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb);
        exp_t x;
        x.req   = req;
        x.addr  = addr;
        x.wdata = wdata;
        x.wstrb = wstrb;
        sb.push_back(x);
    endtask

    // Holds the request until its ready, then drops valid just after the edge.
    task automatic do_txn(input logic idx, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, output int cyc);
        bit done;
        done = 1'b0;
        if (idx) begin
            r1_valid = 1'b1; r1_addr = addr; r1_wdata = wdata; r1_wstrb = wstrb;
        end else begin
            r0_valid = 1'b1; r0_addr = addr; r0_wdata = wdata; r0_wstrb = wstrb;
        end
        cyc = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            done = idx ? r1_ready : r0_ready;
        end
        if (!done) chk("ready_timeout", 64'(done), 64'd1);
        @(posedge clk);
        #1;
        if (idx) r1_valid = 1'b0;
        else r0_valid = 1'b0;
    endtask

    task automatic run_n(input logic idx, input int n, input logic [31:0] base,
                         input logic [3:0] wstrb);
        int cyc;
        for (int k = 0; k < n; k++) begin
            do_txn(idx, base + 32'(k * 16), base ^ 32'h5555_0000, wstrb, cyc);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (r0_ready || r1_ready) begin
                chk("single_ready", 64'(r0_ready & r1_ready), 64'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_ready", 64'({r1_ready, r0_ready}), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("ready_owner", 64'(r1_ready), 64'(e.req));
                    chk("grant", 64'(grant), 64'(e.req));
                    chk("m_addr", 64'(m_addr), 64'(e.addr));
                    chk("m_wdata", 64'(m_wdata), 64'(e.wdata));
                    chk("m_wstrb", 64'(m_wstrb), 64'(e.wstrb));
                    chk("rdata", 64'(e.req ? r1_rdata : r0_rdata), 64'(e.addr ^ KEY));
                    chk("other_rdata", 64'(e.req ? r0_rdata : r1_rdata), 64'd0);
                end
            end else begin
                chk("rdata_gated", {r1_rdata, r0_rdata}, 64'd0);
            end
        end
    end

    initial begin
        int cyc, cyc1;
        rst = 1'b1;
        r0_valid = 1'b0; r0_addr = '0; r0_wdata = '0; r0_wstrb = '0;
        r1_valid = 1'b0; r1_addr = '0; r1_wdata = '0; r1_wstrb = '0;

        // Reset state
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_readies", 64'({r1_ready, r0_ready}), 64'd0);
        chk("rst_rdata", {r1_rdata, r0_rdata}, 64'd0);
        chk("rst_m_addr", 64'(m_addr), 64'd0);
        chk("rst_m_wdata_wstrb", 64'({m_wdata, m_wstrb}), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // Single DMA read, 3-cycle memory
        lat = 3;
        push(1'b0, 32'h100, 32'h0, 4'h0);
        fork
            do_txn(1'b0, 32'h100, 32'h0, 4'h0, cyc);
            begin
                @(negedge clk);
                chk("arb_cycle_m_valid", 64'(m_valid), 64'd0);
                @(negedge clk);
                chk("dma_m_valid", 64'(m_valid), 64'd1);
                chk("dma_busy", 64'(busy), 64'd1);
                chk("dma_m_addr", 64'(m_addr), 64'h100);
                chk("dma_m_wstrb", 64'(m_wstrb), 64'd0);
            end
        join
        chk("dma_read_cycles", 64'(cyc), 64'd5);

        // Simultaneous writes after reset: r0 wins the first tie
        pulse_reset();
        lat = 1;
        push(1'b0, 32'h10, 32'h11, 4'hF);
        push(1'b1, 32'h20, 32'h22, 4'hF);
        fork
            do_txn(1'b0, 32'h10, 32'h11, 4'hF, cyc);
            do_txn(1'b1, 32'h20, 32'h22, 4'hF, cyc1);
        join

        // Continuous contention: strict alternation starting with r0
        lat = 2;
        for (int k = 0; k < 4; k++) begin
            push(1'b0, 32'h1000 + 32'(k * 16), 32'h1000 ^ 32'h5555_0000, 4'h3);
            push(1'b1, 32'h2000 + 32'(k * 16), 32'h2000 ^ 32'h5555_0000, 4'hC);
        end
        fork
            run_n(1'b0, 4, 32'h1000, 4'h3);
            run_n(1'b1, 4, 32'h2000, 4'hC);
        join

        // Zero-latency memory, back-to-back DMA transactions
        lat = 0;
        for (int k = 0; k < 3; k++) begin
            push(1'b0, 32'h3000 + 32'(k * 4), 32'(k), 4'h1);
            do_txn(1'b0, 32'h3000 + 32'(k * 4), 32'(k), 4'h1, cyc);
            chk("zero_lat_cycles", 64'(cyc), 64'd2);
        end
        chk("zero_lat_sb_empty", 64'(sb.size()), 64'd0);

        // Protocol violation: r1 granted, then drops valid before m_ready
        lat = 8;
        r1_valid = 1'b1; r1_addr = 32'h300; r1_wdata = '0; r1_wstrb = 4'h0;
        @(negedge clk);
        chk("viol_arb_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("viol_m_valid", 64'(m_valid), 64'd1);
        chk("viol_grant", 64'(grant), 64'd1);
        r1_valid = 1'b0;
        @(posedge clk); #1;
        chk("viol_back_idle", 64'(busy), 64'd0);
        chk("viol_m_valid_low", 64'(m_valid), 64'd0);
        chk("idle_m_addr", 64'(m_addr), 64'd0);
        // Spurious m_ready while idle
        spur = 1'b1;
        @(negedge clk);
        chk("spur_readies", 64'({r1_ready, r0_ready}), 64'd0);
        chk("spur_busy", 64'(busy), 64'd0);
        @(posedge clk); #1 spur = 1'b0;
        // prio still points at r0 (last served), so the tie goes to r1, then r0
        lat = 1;
        push(1'b1, 32'h310, 32'hA1, 4'hF);
        push(1'b0, 32'h320, 32'hA0, 4'hF);
        fork
            do_txn(1'b1, 32'h310, 32'hA1, 4'hF, cyc1);
            do_txn(1'b0, 32'h320, 32'hA0, 4'hF, cyc);
        join

        // Reset mid-transaction with r1 owning the port
        lat = 20;
        r1_valid = 1'b1; r1_addr = 32'h400; r1_wdata = 32'h44; r1_wstrb = 4'hF;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_m_valid", 64'(m_valid), 64'd1);
        chk("pre_rst_grant", 64'(grant), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_m_valid", 64'(m_valid), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_grant", 64'(grant), 64'd0);
        r1_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        lat = 2;
        push(1'b0, 32'h500, 32'hB0, 4'h5);
        push(1'b1, 32'h600, 32'hB1, 4'hA);
        fork
            do_txn(1'b0, 32'h500, 32'hB0, 4'h5, cyc);
            do_txn(1'b1, 32'h600, 32'hB1, 4'hA, cyc1);
        join

        repeat (3) @(posedge clk);
        chk("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
